axil_reg_req_bridge: RTL

AXI4-Lite slave that converts processor register accesses into the single-cycle reg_req / reg_ack protocol used by the replay-engine register blocks. It sits directly upstream of the replay register files. It drives request, read/write, address and write data, then returns the acknowledged read data as AXI responses. One transaction is outstanding at a time, with a bounded wait for acknowledge.

---
 rtl/axil_reg_req_bridge_pkg.sv | 21 ++
 rtl/axil_reg_req_bridge_if.sv | 53 +++++
 rtl/axil_reg_req_bridge_chan_hold.sv | 41 ++++
 rtl/axil_reg_req_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_req_bridge_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axil_reg_req_bridge_pkg: shared state encoding and response constants.
// Revision: 1.0
// ----------------------------------------------------------------------------
package axil_reg_req_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRESP = 3'd3,
      ST_RRESP = 3'd4
   } bridge_state_t;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam logic [31:0] REG_DEADBEEF    = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/axil_reg_req_bridge_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axil_reg_req_bridge_if: AXI4-Lite slave channels plus the reg_req/reg_ack bus.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface axil_reg_req_bridge_if #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 26
);
   logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic                        s_axi_awvalid;
   logic                        s_axi_awready;
   logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
   logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                        s_axi_wvalid;
   logic                        s_axi_wready;
   logic [1:0]                  s_axi_bresp;
   logic                        s_axi_bvalid;
   logic                        s_axi_bready;
   logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
   logic                        s_axi_arvalid;
   logic                        s_axi_arready;
   logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]                  s_axi_rresp;
   logic                        s_axi_rvalid;
   logic                        s_axi_rready;
   logic                        reg_req;
   logic                        reg_rd_wr_L;
   logic [AXI_ADDR_WIDTH-1:0]   reg_addr;
   logic [AXI_DATA_WIDTH-1:0]   reg_wr_data;
   logic                        reg_ack;
   logic [AXI_DATA_WIDTH-1:0]   reg_rd_data;

   // Bridge side: AXI slave, register-bus requester.
   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
      input  reg_ack, reg_rd_data
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
      output reg_ack, reg_rd_data
   );
endinterface
`default_nettype wire

// File: rtl/axil_reg_req_bridge_chan_hold.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axil_chan_hold: single-entry valid/ready holding register for one AXI channel.
// Revision: 1.0
// ----------------------------------------------------------------------------
module axil_chan_hold #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_enable,
   input  wire logic             i_valid,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_clear,
   output logic                  o_ready,
   output logic                  o_hs,
   output logic                  o_full,
   output logic [WIDTH-1:0]      o_data
);
   logic             r_full;
   logic [WIDTH-1:0] r_data;

   assign o_ready = i_enable && !r_full;
   assign o_hs    = i_valid && o_ready;
   assign o_full  = r_full;
   // Forward the incoming beat so a transaction can start in its handshake cycle.
   assign o_data  = r_full ? r_data : i_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (o_hs) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end
endmodule
`default_nettype wire

// File: rtl/axil_reg_req_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axil_reg_req_bridge: AXI4-Lite slave to single-cycle reg_req/reg_ack bridge.
// Define REG_BRIDGE_TIMEOUT_EN to bound the reg_ack wait. Revision: 1.0
// ----------------------------------------------------------------------------
module axil_reg_req_bridge
   import axil_reg_req_bridge_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 26,
   parameter int TIMEOUT_CYCLES = 64
) (
   input wire logic              clk,
   input wire logic              reset,
   axil_reg_req_bridge_if.slave  bus
);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int WPAY_W = AXI_DATA_WIDTH + STRB_W;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   bridge_state_t             r_state;
   logic                      r_run;
   logic                      r_last_wr;
   logic                      r_req;
   logic                      r_rd_wr_L;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_DATA_WIDTH-1:0] r_wr_data;
   logic                      r_bvalid;
   logic [1:0]                r_bresp;
   logic                      r_rvalid;
   logic [1:0]                r_rresp;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;

   logic                      w_enable, w_ar_enable;
   logic                      w_aw_hs, w_aw_full, w_w_hs, w_w_full, w_ar_hs, w_ar_full;
   logic                      w_aw_have, w_w_have, w_ar_have;
   logic                      w_wr_rdy, w_rd_rdy, w_pick_rd, w_pick_wr, w_strb_ok;
   logic                      w_wr_clear, w_rd_clear;
   logic [AXI_ADDR_WIDTH-1:0] w_aw_addr, w_ar_addr;
   logic [WPAY_W-1:0]         w_w_in, w_w_pay;

`ifdef REG_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tmo_cnt;
   logic             w_tmo;
   assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // r_run keeps every ready low while reset is asserted.
   assign w_enable    = r_run && (r_state == ST_IDLE);
   assign w_ar_enable = w_enable && !w_aw_full && !w_w_full;
   assign w_w_in      = {bus.s_axi_wstrb, bus.s_axi_wdata};
   assign w_wr_clear  = (r_state == ST_WRESP) && bus.s_axi_bready;
   assign w_rd_clear  = (r_state == ST_RRESP) && bus.s_axi_rready;

   axil_chan_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_hold (
      .clk(clk), .reset(reset), .i_enable(w_enable), .i_valid(bus.s_axi_awvalid),
      .i_data(bus.s_axi_awaddr), .i_clear(w_wr_clear), .o_ready(bus.s_axi_awready),
      .o_hs(w_aw_hs), .o_full(w_aw_full), .o_data(w_aw_addr)
   );

   axil_chan_hold #(.WIDTH(WPAY_W)) u_w_hold (
      .clk(clk), .reset(reset), .i_enable(w_enable), .i_valid(bus.s_axi_wvalid),
      .i_data(w_w_in), .i_clear(w_wr_clear), .o_ready(bus.s_axi_wready),
      .o_hs(w_w_hs), .o_full(w_w_full), .o_data(w_w_pay)
   );

   axil_chan_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_ar_hold (
      .clk(clk), .reset(reset), .i_enable(w_ar_enable), .i_valid(bus.s_axi_arvalid),
      .i_data(bus.s_axi_araddr), .i_clear(w_rd_clear), .o_ready(bus.s_axi_arready),
      .o_hs(w_ar_hs), .o_full(w_ar_full), .o_data(w_ar_addr)
   );

   assign w_aw_have = w_aw_full || w_aw_hs;
   assign w_w_have  = w_w_full  || w_w_hs;
   assign w_ar_have = w_ar_full || w_ar_hs;
   assign w_wr_rdy  = w_aw_have && w_w_have;
   // A read stalls while exactly one write half is present.
   assign w_rd_rdy  = w_ar_have && (w_aw_have == w_w_have);
   assign w_pick_rd = w_rd_rdy && (!w_wr_rdy || r_last_wr);
   assign w_pick_wr = w_wr_rdy && !w_pick_rd;
   assign w_strb_ok = &w_w_pay[WPAY_W-1 -: STRB_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_run     <= 1'b0;
         r_last_wr <= 1'b1;
         r_req     <= 1'b0;
         r_rd_wr_L <= 1'b1;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rresp   <= AXI_RESP_OKAY;
         r_rdata   <= '0;
`ifdef REG_BRIDGE_TIMEOUT_EN
         r_tmo_cnt <= '0;
`endif
      end else begin
         r_run <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_rd) begin
                  r_state   <= ST_REQ;
                  r_req     <= 1'b1;
                  r_rd_wr_L <= 1'b1;
                  r_addr    <= w_ar_addr;
                  if (w_wr_rdy) r_last_wr <= 1'b0;
               end else if (w_pick_wr) begin
                  if (w_rd_rdy) r_last_wr <= 1'b1;
                  if (w_strb_ok) begin
                     r_state   <= ST_REQ;
                     r_req     <= 1'b1;
                     r_rd_wr_L <= 1'b0;
                     r_addr    <= w_aw_addr;
                     r_wr_data <= w_w_pay[AXI_DATA_WIDTH-1:0];
                  end else begin
                     r_state  <= ST_WRESP;
                     r_bvalid <= 1'b1;
                     r_bresp  <= AXI_RESP_SLVERR;
                  end
               end
            end
            ST_REQ: begin
               r_req   <= 1'b0;
               r_state <= ST_WAIT;
`ifdef REG_BRIDGE_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (bus.reg_ack) begin
                  if (r_rd_wr_L) begin
                     r_rdata  <= bus.reg_rd_data;
                     r_rresp  <= AXI_RESP_OKAY;
                     r_rvalid <= 1'b1;
                     r_state  <= ST_RRESP;
                  end else begin
                     r_bresp  <= AXI_RESP_OKAY;
                     r_bvalid <= 1'b1;
                     r_state  <= ST_WRESP;
                  end
`ifdef REG_BRIDGE_TIMEOUT_EN
               end else if (w_tmo) begin
                  if (r_rd_wr_L) begin
                     r_rdata  <= AXI_DATA_WIDTH'(REG_DEADBEEF);
                     r_rresp  <= AXI_RESP_SLVERR;
                     r_rvalid <= 1'b1;
                     r_state  <= ST_RRESP;
                  end else begin
                     r_bresp  <= AXI_RESP_SLVERR;
                     r_bvalid <= 1'b1;
                     r_state  <= ST_WRESP;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
               end
            end
            ST_WRESP: begin
               if (bus.s_axi_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            ST_RRESP: begin
               if (bus.s_axi_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.reg_req      = r_req;
   assign bus.reg_rd_wr_L  = r_rd_wr_L;
   assign bus.reg_addr     = r_addr;
   assign bus.reg_wr_data  = r_wr_data;
   assign bus.s_axi_bvalid = r_bvalid;
   assign bus.s_axi_bresp  = r_bresp;
   assign bus.s_axi_rvalid = r_rvalid;
   assign bus.s_axi_rresp  = r_rresp;
   assign bus.s_axi_rdata  = r_rdata;
endmodule
`default_nettype wire
